// File: rtl/attn_core_seq_if.sv
// attn_core_seq_if: instruction bus and handshake bundle between the
// sequencer (master) and the attention core / surrounding control (slave).
interface attn_core_seq_if #(
  parameter int ADDR_W = 4
) ();
  localparam int INST_W = 12 + 2 * ADDR_W;

  logic              start;
  logic [ADDR_W:0]   num_q;
  logic              ofifo_valid;
  logic              sum_out_vld;
  logic              sum_rd_vld;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport master (
    input  start, num_q, ofifo_valid, sum_out_vld, sum_rd_vld,
    output inst, busy, done
  );

  modport slave (
    output start, num_q, ofifo_valid, sum_out_vld, sum_rd_vld,
    input  inst, busy, done
  );
endinterface

// File: rtl/attn_core_seq.sv
// attn_core_seq: self-sequencing instruction generator (KLOAD, QEXEC, DRAIN, WAIT_SUM, NORM).
// Optional macro SEQ_TIMEOUT_EN adds a DRAIN/WAIT_SUM watchdog and a sticky timeout_err output.
module attn_core_seq #(
  parameter int COL    = 8,
  parameter int ADDR_W = 4
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1024
`endif
) (
  input  logic            clk,
  input  logic            reset,
  attn_core_seq_if.master bus
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic            timeout_err
`endif
);
  localparam int INST_W = 12 + 2 * ADDR_W;
  localparam int CNT_W  = ($clog2(COL + 1) > ADDR_W + 1) ? $clog2(COL + 1) : ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [7:0] PMEM_WR  = 8'h01;
  localparam logic [7:0] PMEM_RD  = 8'h02;
  localparam logic [7:0] KMEM_RD  = 8'h08;
  localparam logic [7:0] QMEM_RD  = 8'h20;
  localparam logic [7:0] MAC_LOAD = 8'h40;
  localparam logic [7:0] MAC_EXEC = 8'h80;
  localparam logic [3:0] OFIFO_RD    = 4'h1;
  localparam logic [3:0] DIV         = 4'h2;
  localparam logic [3:0] ACC         = 4'h4;
  localparam logic [3:0] SFP_PMEM_WR = 4'h8;

  typedef enum logic [2:0] {IDLE, KLOAD, QEXEC, DRAIN, WAIT_SUM, NORM} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc, nq_ext;
  logic [ADDR_W:0]   nq, nq_n;
  logic [INST_W-1:0] inst_q, inst_n;
  logic              busy_q, busy_n, done_q, done_n;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tcnt, tcnt_n;
  logic             err_q, err_n;
  assign timeout_err = err_q;
`endif

  function automatic logic [INST_W-1:0] mk_inst(input logic [7:0] ctrl, input logic [ADDR_W-1:0] padd,
                                                input logic [ADDR_W-1:0] qkadd, input logic [3:0] hi);
    return {hi, qkadd, padd, ctrl};
  endfunction

  assign cnt_inc = cnt + 1'b1;
  assign nq_ext  = CNT_W'(nq);

  // Outputs are computed for the upcoming cycle so inst/busy/done all leave flops.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    nq_n    = nq;
    inst_n  = '0;
    done_n  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tcnt_n  = tcnt;
    err_n   = err_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_q == '0) begin
            done_n = 1'b1;
          end else begin
            nq_n    = (bus.num_q > DEPTH_V) ? DEPTH_V : bus.num_q;
            state_n = KLOAD;
            cnt_n   = '0;
            inst_n  = mk_inst(KMEM_RD | MAC_LOAD, '0, '0, '0);
          end
        end
      end
      KLOAD: begin
        cnt_n = cnt_inc;
        if (cnt == CNT_W'(COL)) begin
          state_n = QEXEC;
          cnt_n   = '0;
          inst_n  = mk_inst(QMEM_RD | MAC_EXEC, '0, '0, '0);
        end else if (cnt == CNT_W'(COL - 1)) begin
          inst_n = mk_inst(MAC_LOAD, '0, '0, '0);
        end else begin
          inst_n = mk_inst(KMEM_RD | MAC_LOAD, '0, cnt_inc[ADDR_W-1:0], '0);
        end
      end
      QEXEC: begin
        cnt_n = cnt_inc;
        if (cnt == nq_ext) begin
          state_n = DRAIN;
          cnt_n   = '0;
          if (bus.ofifo_valid) begin
            cnt_n  = CNT_W'(1);
            inst_n = mk_inst(PMEM_WR, '0, '0, OFIFO_RD | ACC);
          end
        end else if (cnt_inc == nq_ext) begin
          inst_n = mk_inst(MAC_EXEC, '0, '0, '0);
        end else begin
          inst_n = mk_inst(QMEM_RD | MAC_EXEC, '0, cnt_inc[ADDR_W-1:0], '0);
        end
      end
      DRAIN: begin
        if (cnt == nq_ext) begin
          state_n = WAIT_SUM;
          cnt_n   = '0;
        end else if (bus.ofifo_valid) begin
          cnt_n  = cnt_inc;
          inst_n = mk_inst(PMEM_WR, cnt[ADDR_W-1:0], '0, OFIFO_RD | ACC);
        end
      end
      WAIT_SUM: begin
        if (bus.sum_out_vld && bus.sum_rd_vld) begin
          state_n = NORM;
          cnt_n   = '0;
          inst_n  = mk_inst(PMEM_RD, '0, '0, DIV | SFP_PMEM_WR);
        end
      end
      NORM: begin
        if (cnt_inc == nq_ext) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n  = cnt_inc;
          inst_n = mk_inst(PMEM_RD, cnt_inc[ADDR_W-1:0], '0, DIV | SFP_PMEM_WR);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
`ifdef SEQ_TIMEOUT_EN
    // The watchdog only fires while the FSM would otherwise keep waiting in DRAIN/WAIT_SUM.
    if (state == IDLE && bus.start) begin
      err_n = 1'b0;
    end
    if ((state == DRAIN || state == WAIT_SUM) && state_n == state) begin
      if (tcnt == TMO_W'(TIMEOUT - 1)) begin
        state_n = IDLE;
        cnt_n   = '0;
        inst_n  = '0;
        tcnt_n  = '0;
        err_n   = 1'b1;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end else if (state_n == DRAIN || state_n == WAIT_SUM) begin
      tcnt_n = '0;
    end
`endif
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      nq     <= '0;
      inst_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tcnt   <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      nq     <= nq_n;
      inst_q <= inst_n;
      busy_q <= busy_n;
      done_q <= done_n;
`ifdef SEQ_TIMEOUT_EN
      tcnt   <= tcnt_n;
      err_q  <= err_n;
`endif
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
